// File: rtl/mine_gen.sv
// mine_gen: Minesweeper board generator.
// Places NUM_MINES mines with a 16-bit Galois LFSR, keeping the first-click tile
// clear, then walks every tile once to fill in its 4-bit neighbour mine count.
// Optional build macro MINE_GEN_SAFE_ZONE_EN also keeps the 8 neighbours of the
// first-click tile clear, so the first click always opens a zero-count area.
module mine_gen #(
    parameter int unsigned GRID_SIZE   = 8,
    parameter int unsigned TOTAL_TILES = GRID_SIZE * GRID_SIZE,
    parameter int unsigned NUM_MINES   = 10,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(TOTAL_TILES)-1:0] start_index,
    output logic [TOTAL_TILES-1:0]         mine_map,
    output logic [TOTAL_TILES*4-1:0]       adj,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned IW = $clog2(TOTAL_TILES);
    localparam int unsigned CW = $clog2(NUM_MINES + 1);
    localparam int          G  = int'(GRID_SIZE);
    localparam int          T  = int'(TOTAL_TILES);

    typedef enum logic [1:0] {StIdle, StPlace, StCount, StDone} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic [IW-1:0] root;
    logic [IW-1:0] tile;
    logic [CW-1:0] placed;
    logic [IW-1:0] cand;
    logic          cand_ok;
    logic [3:0]    nb_count;

    // Galois LFSR step, polynomial x^16+x^14+x^13+x^11+1
    always_comb begin
        lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    end

    // Candidate tile for this cycle and whether it may take a mine
    always_comb begin
`ifdef MINE_GEN_SAFE_ZONE_EN
        int dr;
        int dc;
`endif
        cand    = lfsr[IW-1:0];
        cand_ok = 1'b1;
        if (int'(cand) >= T) begin
            cand_ok = 1'b0;
        end else if (mine_map[cand]) begin
            cand_ok = 1'b0;
        end
`ifdef MINE_GEN_SAFE_ZONE_EN
        // Row/column distance to the root; within one in both means excluded
        dr = int'(cand) / G - int'(root) / G;
        dc = int'(cand) % G - int'(root) % G;
        if (dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1) begin
            cand_ok = 1'b0;
        end
`else
        if (cand == root) begin
            cand_ok = 1'b0;
        end
`endif
    end

    // Mined 8-neighbours of the tile being counted, no wrap at grid edges
    always_comb begin
        int            tr;
        int            tc;
        int            r;
        int            c;
        logic [IW-1:0] ni;
        nb_count = '0;
        tr       = int'(tile) / G;
        tc       = int'(tile) % G;
        r        = 0;
        c        = 0;
        ni       = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = tr + dr;
                c = tc + dc;
                if (!(dr == 0 && dc == 0) && r >= 0 && r < G && c >= 0 && c < G) begin
                    ni       = IW'(r * G + c);
                    nb_count = nb_count + {3'b000, mine_map[ni]};
                end
            end
        end
    end

    // Board FSM with registered outputs; the LFSR free-runs in every state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StIdle;
            lfsr     <= LFSR_SEED;
            root     <= '0;
            tile     <= '0;
            placed   <= '0;
            mine_map <= '0;
            adj      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                StIdle: begin
                    if (start) begin
                        root     <= start_index;
                        tile     <= '0;
                        placed   <= '0;
                        mine_map <= '0;
                        adj      <= '0;
                        busy     <= 1'b1;
                        state    <= StPlace;
                    end
                end
                StPlace: begin
                    if (placed == CW'(NUM_MINES)) begin
                        state <= StCount;
                    end else if (cand_ok) begin
                        mine_map[cand] <= 1'b1;
                        placed         <= placed + 1'b1;
                    end
                end
                StCount: begin
                    adj[{tile, 2'b00} +: 4] <= nb_count;
                    if (tile == IW'(TOTAL_TILES - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        tile <= tile + 1'b1;
                    end
                end
                StDone: begin
                    // Board held until reset; start is ignored
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
